weight_display_ctrl: RTL and testbench

Sequencing front end for the six-digit seven-segment scan driver. It accepts signed 24-bit load-cell readings over a valid/ready handshake and converts each magnitude to six BCD digits with a sequential shift-add-3 (double-dabble) engine. It also sets sign and overflow flags and rate-limits display updates so the digits stay readable. Its `bcd_out` bus feeds the scan driver's 24-bit BCD input directly.

---
 rtl/weight_display_ctrl.sv | 134 +++++++++++++
 tb/tb_weight_display_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/weight_display_ctrl.sv
// weight_display_ctrl
// Front end for the six-digit seven-segment scan driver. Accepts a signed
// 24-bit load-cell reading over valid/ready, converts its magnitude to six
// BCD digits with a sequential shift-add-3 engine (24 shift cycles), flags
// sign and overflow, and rate-limits display updates with a hold timer.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   reading available
//   in_ready   block can accept a reading (IDLE and hold timer expired)
//   in_data    reading, two's complement, sampled on the handshake edge
//   bcd_out    six BCD digits, [3:0] units ... [23:20] 10^5 digit
//   neg_out    displayed value is negative
//   ovf_out    magnitude exceeded 999999, bcd_out saturated to 999999
//   bcd_valid  one-cycle pulse with each new bcd_out/neg_out/ovf_out
//   busy       conversion in progress (state is not IDLE)
module weight_display_ctrl #(
    parameter int REFRESH_DIV = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_data,
    output logic [23:0] bcd_out,
    output logic        neg_out,
    output logic        ovf_out,
    output logic        bcd_valid,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [23:0] HOLD_LOAD = 24'(REFRESH_DIV - 1);
    localparam logic [23:0] MAX_DISP  = 24'd999999;

    state_t      state, state_next;
    logic [23:0] timer;
    logic [4:0]  cnt;
    logic [23:0] scratch;
    logic [23:0] mag;
    logic        sign;
    logic        ovf;
    logic [23:0] scratch_adj;

    // Two's-complement magnitude; 0x800000 maps to 8388608 as unsigned.
    function automatic logic [23:0] abs_mag(input logic [23:0] d);
        return d[23] ? (~d + 24'd1) : d;
    endfunction

    // Shift-add-3 correction: any digit >= 5 gets +3 before the shift so
    // that doubling carries correctly into the next decimal digit.
    function automatic logic [23:0] add3_digits(input logic [23:0] s);
        logic [23:0] r;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = (s[i*4 +: 4] >= 4'd5) ? s[i*4 +: 4] + 4'd3 : s[i*4 +: 4];
        end
        return r;
    endfunction

    // On overflow the scratch contents are meaningless; show all nines.
    function automatic logic [23:0] sat_bcd(input logic [23:0] s, input logic o);
        return o ? 24'h999999 : s;
    endfunction

    assign in_ready    = (state == IDLE) && (timer == 24'd0);
    assign busy        = (state != IDLE);
    assign scratch_adj = add3_digits(scratch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_next = SHIFT;
            SHIFT:   if (cnt == 5'd23) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer     <= '0;
            cnt       <= '0;
            scratch   <= '0;
            mag       <= '0;
            sign      <= 1'b0;
            ovf       <= 1'b0;
            bcd_out   <= '0;
            neg_out   <= 1'b0;
            ovf_out   <= 1'b0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            if (timer != 24'd0) timer <= timer - 24'd1;
            case (state)
                // capture: sign, magnitude and overflow decided up front
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sign    <= in_data[23];
                        mag     <= abs_mag(in_data);
                        ovf     <= abs_mag(in_data) > MAX_DISP;
                        scratch <= '0;
                        cnt     <= '0;
                    end
                end
                // convert: correct digits, then shift {scratch, mag} left by one
                SHIFT: begin
                    scratch <= {scratch_adj[22:0], mag[23]};
                    mag     <= {mag[22:0], 1'b0};
                    cnt     <= cnt + 5'd1;
                end
                // publish: update display and start the hold interval
                DONE: begin
                    bcd_out   <= sat_bcd(scratch, ovf);
                    neg_out   <= sign;
                    ovf_out   <= ovf;
                    bcd_valid <= 1'b1;
                    timer     <= HOLD_LOAD;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_display_ctrl.sv
module tb_weight_display_ctrl;

    localparam int R = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = '0;
    logic [23:0] bcd_out;
    logic        neg_out;
    logic        ovf_out;
    logic        bcd_valid;
    logic        busy;

    weight_display_ctrl #(.REFRESH_DIV(R)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bcd_out   (bcd_out),
        .neg_out   (neg_out),
        .ovf_out   (ovf_out),
        .bcd_valid (bcd_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // reference model state, in units of rising-edge index
    int          hs_edge    = -1000;
    int          due_edge   = -1;
    int          ready_from = -1;
    logic [23:0] pend_bcd, exp_bcd;
    logic        pend_neg, pend_ovf, exp_neg, exp_ovf, exp_vld, exp_busy, exp_rdy;
    bit          rdy_before;
    int          v_int, m_int;

    function automatic logic [23:0] to_bcd(input int m);
        logic [23:0] r;
        r = '0;
        if (m > 999999) return 24'h999999;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        exp_bcd = '0; exp_neg = 0; exp_ovf = 0; exp_vld = 0;
        pend_bcd = '0; pend_neg = 0; pend_ovf = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                hs_edge = -1000; due_edge = -1; ready_from = -1;
                exp_bcd = '0; exp_neg = 0; exp_ovf = 0; exp_vld = 0;
            end else begin
                rdy_before = (cyc - 1 >= ready_from);
                exp_vld = 0;
                if (cyc == due_edge) begin
                    exp_bcd = pend_bcd; exp_neg = pend_neg; exp_ovf = pend_ovf; exp_vld = 1;
                end
                if (in_valid && rdy_before) begin
                    v_int = int'($signed(in_data));
                    m_int = (v_int < 0) ? -v_int : v_int;
                    hs_edge    = cyc;
                    due_edge   = cyc + 25;
                    ready_from = cyc + 24 + R;
                    pend_bcd   = to_bcd(m_int);
                    pend_neg   = (v_int < 0);
                    pend_ovf   = (m_int > 999999);
                end
            end
            #1;
            exp_busy = (cyc >= hs_edge) && (cyc < hs_edge + 25);
            exp_rdy  = (cyc >= ready_from);
            chk("cycle_outputs",
                {4'h0, bcd_out, neg_out, ovf_out, bcd_valid, busy, in_ready},
                {4'h0, exp_bcd, exp_neg, exp_ovf, exp_vld, exp_busy, exp_rdy});
        end
    end

    task automatic wait_ready(output bit ok);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        ok = in_ready;
        if (!ok) chk("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic convert(input string nm, input logic [23:0] v,
                           input logic [23:0] eb, input logic en, input logic eo);
        bit ok;
        int n;
        wait_ready(ok);
        if (!ok) return;
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!bcd_valid && n < 40);
        chk({nm, "_latency"}, 32'(n), 32'd25);
        chk({nm, "_bcd"}, {8'h0, bcd_out}, {8'h0, eb});
        chk({nm, "_neg"}, 32'(neg_out), 32'(en));
        chk({nm, "_ovf"}, 32'(ovf_out), 32'(eo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int  last_hs, nhs;
        bit  ok;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_bcd", {8'h0, bcd_out}, 32'h0);
        chk("reset_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        convert("pos",      24'd123456,  24'h123456, 1'b0, 1'b0);
        convert("neg42",    24'hFFFFD6,  24'h000042, 1'b1, 1'b0);
        convert("pos_ovf",  24'd1000000, 24'h999999, 1'b0, 1'b1);
        convert("min_ovf",  24'h800000,  24'h999999, 1'b1, 1'b1);
        convert("max_ok",   24'd999999,  24'h999999, 1'b0, 1'b0);
        convert("zero",     24'd0,       24'h000000, 1'b0, 1'b0);
        convert("neg_max",  24'hF0BDC1,  24'h999999, 1'b1, 1'b0);
        convert("neg_ovf",  24'hF0BDC0,  24'h999999, 1'b1, 1'b1);

        // rate limit: in_valid held high, data changing every cycle
        last_hs = -1;
        nhs = 0;
        in_data = 24'd500000;
        for (int i = 0; i < 520; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = in_data + 24'd1;
            if (in_ready) begin
                if (last_hs >= 0) chk("rate_gap", 32'(cyc + 1 - last_hs), 32'd125);
                last_hs = cyc + 1;
                nhs++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("rate_handshakes", 32'(nhs >= 4), 32'd1);

        // randomized readings and valid pattern
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0:       in_data = 24'h800000;
                1:       in_data = 24'(999998 + $urandom_range(0, 3));
                2:       in_data = 24'(-int'($urandom_range(0, 1000001)));
                3:       in_data = 24'($urandom_range(0, 999999));
                default: in_data = 24'($urandom);
            endcase
        end
        @(negedge clk);
        in_valid = 1'b0;

        // reset in the middle of a conversion
        convert("pre_rst", 24'd654321, 24'h654321, 1'b0, 1'b0);
        wait_ready(ok);
        in_valid = 1'b1;
        in_data  = 24'hFFFF85;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("rst_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_bcd",   {8'h0, bcd_out}, 32'h0);
        chk("rst_neg",   32'(neg_out), 32'd0);
        chk("rst_ovf",   32'(ovf_out), 32'd0);
        chk("rst_valid", 32'(bcd_valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready_after", 32'(in_ready), 32'd1);
        repeat (40) @(negedge clk);
        convert("post_rst", 24'hFFFF85, 24'h000123, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
